// File: rtl/dmem_io_responder.sv
// Data-memory responder: word RAM with WAIT_STATES-cycle loads on stall, plus display/switch MMIO at 0xFFF0-0xFFFF.
// Stores and I/O loads are single-cycle; define DMEM_IO_DEBOUNCE_EN to add DEB_CYCLES switch debouncing.
module dmem_io_responder #(
   parameter int ADDR_W      = 7,
   parameter int WAIT_STATES = 1,
   parameter int DEB_CYCLES  = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] dmemaddr,
   input  logic [15:0] dmemwdata,
   input  logic        dmemwrite,
   input  logic        dmemread,
   input  logic        io_sw0,
   input  logic        io_sw1,
   output logic [15:0] dmemrdata,
   output logic        stall,
   output logic [6:0]  io_display
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t             state_q;
   logic [2:0]         cnt_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [6:0]         disp_q;
   logic [15:0]        rdata_q;
   logic [15:0]        mem [0:(1<<ADDR_W)-1];

   logic               io_hit;
   logic               ram_hit;
   logic               wr_req;
   logic               rd_req;
   logic               ram_ld;
   logic [ADDR_W-1:0]  idx;
   logic [ADDR_W-1:0]  rd_idx;
   logic [15:0]        io_rdata;
   logic [1:0]         sync1_q;
   logic [1:0]         sync2_q;
   logic [1:0]         sw_clean;
   logic               unused_addr;

   assign idx         = dmemaddr[ADDR_W:1];
   assign io_hit      = &dmemaddr[15:4];
   assign ram_hit     = ~io_hit;
   assign wr_req      = dmemwrite & (state_q == ST_IDLE);
   // A simultaneous write wins: the read half of the request is dropped.
   assign rd_req      = dmemread & ~dmemwrite & (state_q == ST_IDLE);
   assign ram_ld      = rd_req & ram_hit;
   assign rd_idx      = (state_q == ST_IDLE) ? idx : addr_q;
   assign io_display  = disp_q;
   assign unused_addr = ^dmemaddr;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         disp_q  <= 7'h7F;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ram_ld && (WAIT_STATES > 0)) begin
                  addr_q <= idx;
                  if (WAIT_STATES == 1) begin
                     state_q <= ST_DONE;
                  end else begin
                     state_q <= ST_WAIT;
                     cnt_q   <= 3'(WAIT_STATES - 2);
                  end
               end
            end
            ST_WAIT: begin
               if (cnt_q == 3'd0) begin
                  state_q <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
         if (wr_req && io_hit && (dmemaddr[3:1] == 3'd0)) begin
            disp_q <= dmemwdata[6:0];
         end
      end
   end

   // RAM has no reset; the read register is only exposed in DONE.
   always_ff @(posedge clock) begin
      if (wr_req && ram_hit) begin
         mem[idx] <= dmemwdata;
      end
      rdata_q <= mem[rd_idx];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= {io_sw1, io_sw0};
         sync2_q <= sync1_q;
      end
   end

`ifdef DMEM_IO_DEBOUNCE_EN
   logic [15:0] deb_cnt_q [2];
   logic [1:0]  clean_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         clean_q      <= '0;
         deb_cnt_q[0] <= '0;
         deb_cnt_q[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != clean_q[i]) begin
               if (deb_cnt_q[i] == 16'(DEB_CYCLES - 1)) begin
                  clean_q[i]   <= sync2_q[i];
                  deb_cnt_q[i] <= '0;
               end else begin
                  deb_cnt_q[i] <= deb_cnt_q[i] + 16'd1;
               end
            end else begin
               deb_cnt_q[i] <= '0;
            end
         end
      end
   end

   assign sw_clean = clean_q;
`else
   logic [15:0] unused_deb;

   assign unused_deb = 16'(DEB_CYCLES);
   assign sw_clean   = sync2_q;
`endif

   always_comb begin
      case (dmemaddr[3:1])
         3'd0:    io_rdata = {9'b0, disp_q};
         3'd1:    io_rdata = {15'b0, sw_clean[0]};
         3'd2:    io_rdata = {15'b0, sw_clean[1]};
         default: io_rdata = '0;
      endcase
   end

   always_comb begin
      stall     = 1'b0;
      dmemrdata = '0;
      case (state_q)
         ST_IDLE: begin
            if (rd_req) begin
               if (io_hit) begin
                  dmemrdata = io_rdata;
               end else if (WAIT_STATES == 0) begin
                  dmemrdata = mem[idx];
               end else begin
                  stall = 1'b1;
               end
            end
         end
         ST_WAIT: stall = 1'b1;
         ST_DONE: dmemrdata = rdata_q;
         default: ;
      endcase
      // Reset must release the pipeline immediately, even with dmemread held.
      if (!reset) begin
         stall     = 1'b0;
         dmemrdata = '0;
      end
   end

endmodule

// File: tb/tb_dmem_io_responder.sv
// Bench for dmem_io_responder: one instance with WAIT_STATES=1, one with WAIT_STATES=3.
module tb_dmem_io_responder;

   logic        clock = 1'b0;
   logic        rst_n [2];
   logic [15:0] addr  [2];
   logic [15:0] wdata [2];
   logic [15:0] rdata [2];
   logic        wr    [2];
   logic        rd    [2];
   logic        stl   [2];
   logic [6:0]  disp  [2];
   logic        sw0;
   logic        sw1;
   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_q [$];
   logic [15:0] seen;

`ifdef DMEM_IO_DEBOUNCE_EN
   localparam int          SW_LAT      = 6;
   localparam logic [15:0] GLITCH_SEEN = 16'h0000;
`else
   localparam int          SW_LAT      = 2;
   localparam logic [15:0] GLITCH_SEEN = 16'h0001;
`endif

   always #5 clock = ~clock;

   dmem_io_responder #(.ADDR_W(7), .WAIT_STATES(1), .DEB_CYCLES(4)) u_ws1 (
      .clock(clock), .reset(rst_n[0]), .dmemaddr(addr[0]), .dmemwdata(wdata[0]),
      .dmemwrite(wr[0]), .dmemread(rd[0]), .io_sw0(sw0), .io_sw1(sw1),
      .dmemrdata(rdata[0]), .stall(stl[0]), .io_display(disp[0])
   );

   dmem_io_responder #(.ADDR_W(7), .WAIT_STATES(3), .DEB_CYCLES(4)) u_ws3 (
      .clock(clock), .reset(rst_n[1]), .dmemaddr(addr[1]), .dmemwdata(wdata[1]),
      .dmemwrite(wr[1]), .dmemread(rd[1]), .io_sw0(1'b0), .io_sw1(1'b0),
      .dmemrdata(rdata[1]), .stall(stl[1]), .io_display(disp[1])
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic store(input int s, input logic [15:0] a, input logic [15:0] d);
      @(posedge clock); #1;
      addr[s]  = a;
      wdata[s] = d;
      wr[s]    = 1'b1;
      rd[s]    = 1'b0;
      @(posedge clock); #1;
      wr[s] = 1'b0;
   endtask

   // Issue a load, count stall cycles, pop the expected word when data is valid.
   task automatic load(input int s, input logic [15:0] a, input logic [15:0] exp,
                       input int exp_stall, input bit no_wait, input string tag);
      int n = 0;
      if (!no_wait) begin
         @(posedge clock); #1;
      end
      addr[s] = a;
      rd[s]   = 1'b1;
      wr[s]   = 1'b0;
      exp_q.push_back(exp);
      @(negedge clock);
      while (stl[s] && n < 20) begin
         n++;
         @(negedge clock);
      end
      chk({tag, "_stall_cycles"}, n, exp_stall);
      chk(tag, rdata[s], exp_q.pop_front());
      @(posedge clock); #1;
      rd[s] = 1'b0;
      @(negedge clock);
      chk({tag, "_idle"}, {stl[s], rdata[s]}, 17'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      for (int s = 0; s < 2; s++) begin
         rst_n[s] = 1'b0;
         addr[s]  = '0;
         wdata[s] = '0;
         wr[s]    = 1'b0;
         rd[s]    = 1'b0;
      end
      sw0 = 1'b0;
      sw1 = 1'b0;
      repeat (3) @(negedge clock);
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;
      @(negedge clock);
      for (int s = 0; s < 2; s++) begin
         chk($sformatf("rst_disp%0d", s), disp[s], 7'h7F);
         chk($sformatf("rst_stall%0d", s), stl[s], 1'b0);
         chk($sformatf("rst_rdata%0d", s), rdata[s], 16'h0);
      end

      store(0, 16'h0010, 16'h1234);
      load(0, 16'h0010, 16'h1234, 1, 0, "ws1_ram");
      store(1, 16'h0020, 16'hBEEF);
      load(1, 16'h0020, 16'hBEEF, 3, 0, "ws3_ram");

      // Load in the cycle right after the store commits.
      store(0, 16'h0012, 16'h7777);
      load(0, 16'h0012, 16'h7777, 1, 1, "st_ld_b2b");

      store(0, 16'hFFF0, 16'h0040);
      chk("disp_write", disp[0], 7'h40);
      load(0, 16'hFFF0, 16'h0040, 0, 0, "disp_read");
      store(0, 16'hFFF2, 16'h1234);
      chk("disp_after_sw_write", disp[0], 7'h40);
      load(0, 16'hFFF2, 16'h0000, 0, 0, "sw0_after_write");
      store(0, 16'hFFF8, 16'hFFFF);
      load(0, 16'hFFF8, 16'h0000, 0, 0, "io_unmapped");
      chk("disp_after_unmapped", disp[0], 7'h40);

      @(posedge clock); #1;
      addr[0]  = 16'h0030;
      wdata[0] = 16'h5555;
      wr[0]    = 1'b1;
      rd[0]    = 1'b1;
      @(negedge clock);
      chk("rdwr_stall", stl[0], 1'b0);
      chk("rdwr_rdata", rdata[0], 16'h0);
      @(posedge clock); #1;
      wr[0] = 1'b0;
      rd[0] = 1'b0;
      load(0, 16'h0030, 16'h5555, 1, 0, "rdwr_ram");

      store(0, 16'h0100, 16'hA5A5);
      load(0, 16'h0000, 16'hA5A5, 1, 0, "alias");

      // Three-cycle glitch on sw0.
      @(posedge clock); #1;
      addr[0] = 16'hFFF2;
      rd[0]   = 1'b1;
      sw0     = 1'b1;
      seen    = '0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clock);
         seen = seen | rdata[0];
         if (k == 3) sw0 = 1'b0;
      end
      chk("sw0_glitch", seen, GLITCH_SEEN);
      repeat (8) @(negedge clock);

      @(posedge clock); #1;
      sw0 = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         chk($sformatf("sw0_hold_k%0d", k), rdata[0], (k >= SW_LAT) ? 16'h1 : 16'h0);
      end
      rd[0] = 1'b0;

      load(0, 16'hFFF4, 16'h0000, 0, 0, "sw1_low");
      sw1 = 1'b1;
      repeat (10) @(negedge clock);
      load(0, 16'hFFF4, 16'h0001, 0, 0, "sw1_high");

      // Reset pulse while u_ws3 sits in WAIT.
      @(posedge clock); #1;
      addr[1] = 16'h0020;
      rd[1]   = 1'b1;
      @(negedge clock);
      @(negedge clock);
      chk("ws3_wait_stall", stl[1], 1'b1);
      #2;
      rst_n[1] = 1'b0;
      #1;
      chk("rst_mid_stall", stl[1], 1'b0);
      chk("rst_mid_rdata", rdata[1], 16'h0);
      rd[1] = 1'b0;
      @(negedge clock);
      rst_n[1] = 1'b1;
      chk("rst_mid_disp", disp[1], 7'h7F);
      load(1, 16'h0020, 16'hBEEF, 3, 0, "ws3_after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
